caesar_stream_dec: RTL and testbench

- Receive-side counterpart of the byte cipher encoder.
- Accepts a stream of ciphertext ASCII bytes over a valid/ready handshake and removes a Caesar shift from letters (A–Z, a–z, modulo 26); all other bytes pass through unchanged.
- Decoded bytes are buffered in a small output FIFO with their own valid/ready handshake.
- Sits between the link receiver and the plaintext consumer.

---
 rtl/cipher_pkg.sv | 18 +
 rtl/caesar_shift_dec.sv | 36 +++
 rtl/caesar_stream_dec.sv | 181 ++++++++++++++++++
 tb/tb_caesar_stream_dec.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared constants and types for the Caesar stream cipher blocks.
package cipher_pkg;

   localparam int KEY_W_DEFAULT = 3;

   localparam logic [7:0] ALPHA_LEN = 8'd26;
   localparam logic [7:0] ASCII_UA  = 8'd65;
   localparam logic [7:0] ASCII_UZ  = 8'd90;
   localparam logic [7:0] ASCII_LA  = 8'd97;
   localparam logic [7:0] ASCII_LZ  = 8'd122;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/caesar_shift_dec.sv
// Combinational Caesar decode of one byte: letters shifted back modulo 26,
// everything else passed through. Shift must stay below 26.
module caesar_shift_dec
   import cipher_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEFAULT
) (
   input  logic [7:0]       in_byte,
   input  logic [KEY_W-1:0] shift,
   output logic [7:0]       out_byte
);

   logic [8:0] diff_s;

   // Subtract the shift and fold letters that fell below their base back by 26
   always_comb begin
      diff_s   = {1'b0, in_byte} - 9'(shift);
      out_byte = in_byte;
      if (in_byte >= ASCII_UA && in_byte <= ASCII_UZ) begin
         if (diff_s < {1'b0, ASCII_UA}) begin
            out_byte = 8'(diff_s + 9'(ALPHA_LEN));
         end else begin
            out_byte = diff_s[7:0];
         end
      end else if (in_byte >= ASCII_LA && in_byte <= ASCII_LZ) begin
         if (diff_s < {1'b0, ASCII_LA}) begin
            out_byte = 8'(diff_s + 9'(ALPHA_LEN));
         end else begin
            out_byte = diff_s[7:0];
         end
      end else begin
         out_byte = in_byte;
      end
   end

endmodule

// File: rtl/caesar_stream_dec.sv
// Streaming Caesar decoder with key-change drain and small output FIFO.
// Optional rolling shift: define CAESAR_ROLLING_KEY_EN.
module caesar_stream_dec
   import cipher_pkg::*;
#(
   parameter int KEY_W      = KEY_W_DEFAULT,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_load,
   input  logic [KEY_W-1:0] key_in,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] byte_count,
   output logic             busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   state_t           state_r, state_nxt_s;
   logic [KEY_W-1:0] key_r, pending_r, pend_nxt_s, apply_key_s, shift_s;
   logic             apply_s, in_ready_s, accept_s, pop_s;
   logic             fifo_full_s, fifo_empty_s;
   logic [7:0]       dec_byte_s;
   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [OCC_W-1:0] occ_r;
   logic [CNT_W-1:0] byte_count_r;

   assign fifo_full_s  = (occ_r == OCC_W'(FIFO_DEPTH));
   assign fifo_empty_s = (occ_r == {OCC_W{1'b0}});
   assign accept_s     = in_valid & in_ready_s;
   assign pop_s        = !fifo_empty_s & out_ready;

   assign in_ready   = in_ready_s;
   assign out_valid  = !fifo_empty_s;
   assign out_data   = mem_r[rd_ptr_r];
   assign byte_count = byte_count_r;
   assign busy       = (state_r != IDLE) || !fifo_empty_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, handshake and key-apply decisions
   always_comb begin
      state_nxt_s = state_r;
      in_ready_s  = 1'b0;
      apply_s     = 1'b0;
      apply_key_s = key_r;
      pend_nxt_s  = pending_r;
      case (state_r)
         IDLE: begin
            if (key_load) begin
               apply_s     = 1'b1;
               apply_key_s = key_in;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            in_ready_s = !fifo_full_s;
            if (key_load) begin
               pend_nxt_s  = key_in;
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (key_load) begin
               pend_nxt_s = key_in;
            end else begin
               pend_nxt_s = pending_r;
            end
            // A key_load landing on the empty cycle wins over the older pending key
            if (fifo_empty_s) begin
               apply_s     = 1'b1;
               apply_key_s = pend_nxt_s;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Base key, pending key and accepted-byte counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r        <= {KEY_W{1'b0}};
         pending_r    <= {KEY_W{1'b0}};
         byte_count_r <= {CNT_W{1'b0}};
      end else begin
         pending_r <= pend_nxt_s;
         if (apply_s) begin
            key_r        <= apply_key_s;
            byte_count_r <= {CNT_W{1'b0}};
         end else if (accept_s && (byte_count_r != {CNT_W{1'b1}})) begin
            byte_count_r <= byte_count_r + CNT_W'(1'b1);
         end else begin
            byte_count_r <= byte_count_r;
         end
      end
   end

`ifdef CAESAR_ROLLING_KEY_EN
   logic [KEY_W-1:0] shift_r;

   // Rolling shift: reload on key apply, advance (wrapping) per accepted byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= {KEY_W{1'b0}};
      end else if (apply_s) begin
         shift_r <= apply_key_s;
      end else if (accept_s) begin
         shift_r <= shift_r + KEY_W'(1'b1);
      end else begin
         shift_r <= shift_r;
      end
   end

   assign shift_s = shift_r;
`else
   assign shift_s = key_r;
`endif

   caesar_shift_dec #(
      .KEY_W (KEY_W)
   ) u_shift_dec (
      .in_byte  (in_data),
      .shift    (shift_s),
      .out_byte (dec_byte_s)
   );

   // Output FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'd0;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {OCC_W{1'b0}};
      end else begin
         if (accept_s) begin
            mem_r[wr_ptr_r] <= dec_byte_s;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({accept_s, pop_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
            2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: tb/tb_caesar_stream_dec.sv
// Scoreboard bench for caesar_stream_dec: expected bytes queued at accept,
// popped and compared by a monitor whenever the FIFO head is consumed.
module tb_caesar_stream_dec;

   logic        clk;
   logic        rst_n;
   logic        key_load;
   logic [2:0]  key_in;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic [15:0] byte_count;
   logic        busy;

   int          n_cmp;
   int          n_err;
   logic [7:0]  exp_q [$];

   caesar_stream_dec dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key_in     (key_in),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .byte_count (byte_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive point: 2 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load_key(input logic [2:0] k);
      key_load = 1'b1;
      key_in   = k;
      tick();
      key_load = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      check("accept_wait", {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
         exp_q.push_back(e);
         tick();
      end else begin
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check("drain_wait", exp_q.size(), 32'd0);
      tick();
   endtask

   // Monitor: compare every consumed FIFO head against the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: got %0d expected none", out_data);
         end else begin
            check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      key_load  = 1'b0;
      key_in    = 3'd0;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_byte_count", {16'd0, byte_count}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // Basic decode with 1-cycle latency
      out_ready = 1'b1;
      load_key(3'd3);
      send(8'd68, 8'd65);
      check("lat_valid_D", {31'd0, out_valid}, 32'd1);
      check("lat_data_D", {24'd0, out_data}, 32'd65);
      send(8'd102, 8'd99);
      check("lat_valid_f", {31'd0, out_valid}, 32'd1);
      check("lat_data_f", {24'd0, out_data}, 32'd99);
      check("count_2", {16'd0, byte_count}, 32'd2);

      // Wrap-around and pass-through
      send(8'd65, 8'd88);
      send(8'd97, 8'd120);
      send(8'd53, 8'd53);
      check("count_5", {16'd0, byte_count}, 32'd5);
      load_key(3'd0);
      send(8'd90, 8'd90);
      check("count_after_key0", {16'd0, byte_count}, 32'd1);
      wait_empty();

      // Backpressure with key 1
      out_ready = 1'b0;
      load_key(3'd1);
      send(8'd66, 8'd65);
      send(8'd67, 8'd66);
      in_valid = 1'b1;
      in_data  = 8'd68;
      tick();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_1", {24'd0, out_data}, 32'd65);
      repeat (3) tick();
      check("bp_hold_2", {24'd0, out_data}, 32'd65);
      check("bp_in_ready_2", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      send(8'd68, 8'd67);
      wait_empty();

      // Key change mid-stream drains first
      out_ready = 1'b0;
      load_key(3'd2);
      send(8'd74, 8'd72);
      load_key(3'd5);
      check("drain_in_ready_1", {31'd0, in_ready}, 32'd0);
      check("drain_busy", {31'd0, busy}, 32'd1);
      tick();
      check("drain_in_ready_2", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      send(8'd72, 8'd67);
      check("count_restart", {16'd0, byte_count}, 32'd1);
      wait_empty();

      // Reset with a full FIFO
      out_ready = 1'b0;
      send(8'd70, 8'd65);
      send(8'd71, 8'd66);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_count", {16'd0, byte_count}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'd81;
      repeat (3) tick();
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;

      // Shift 6 on 'D' three times; rolling mode steps the shift 6,7,0
      out_ready = 1'b1;
      load_key(3'd6);
`ifdef CAESAR_ROLLING_KEY_EN
      send(8'd68, 8'd88);
      send(8'd68, 8'd87);
      send(8'd68, 8'd68);
`else
      send(8'd68, 8'd88);
      send(8'd68, 8'd88);
      send(8'd68, 8'd88);
`endif
      wait_empty();
      check("final_count", {16'd0, byte_count}, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
